// File: rtl/ft600_rx_frame_parser.sv
// ft600_rx_frame_parser: unpacks FT600 words into a byte FIFO and parses [SYNC][LEN][PAYLOAD][CSUM] frames
// Ports: ftdi_clk/rst_n (async active-low); in_valid/in_data/in_be captured words, in_afull backpressure;
// out_valid/out_data/out_last/out_ready payload stream; frame_ok/frame_err/err_code per-frame status;
// overflow sticky drop flag cleared by clear_overflow.
module ft600_rx_frame_parser #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         MAX_LEN    = 64
) (
  input  logic        ftdi_clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_be,
  output logic        in_afull,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        overflow,
  input  logic        clear_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1;
  logic [CW-1:0] count, count_nxt, free;
  logic [1:0] n_wr, nw;
  logic drop, pop, empty, ok_nxt, err_nxt;
  logic [1:0] code_nxt;
  logic [7:0] head, remaining, csum;
  // Space is judged against the pre-pop count, so a word is never accepted on the strength of a same-cycle pop.
  always_comb begin
    n_wr = in_valid ? {1'b0, in_be[0]} + {1'b0, in_be[1]} : 2'd0;
    free = CW'(FIFO_DEPTH) - count;
    drop = n_wr != 2'd0 && free < CW'(n_wr);
    nw = drop ? 2'd0 : n_wr;
    wr_ptr1 = wr_ptr + AW'(1);
    count_nxt = count + CW'(nw) - CW'(pop);
    head = mem[rd_ptr];
    empty = count == '0;
  end
  always_ff @(posedge ftdi_clk) begin
    if (nw != 2'd0) mem[wr_ptr] <= in_be[0] ? in_data[7:0] : in_data[15:8];
    if (nw == 2'd2) mem[wr_ptr1] <= in_data[15:8];
  end
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    ok_nxt = 1'b0;
    err_nxt = 1'b0;
    code_nxt = err_code;
    case (state)
      HUNT: if (!empty) begin
        pop = 1'b1;
        state_nxt = head == SYNC_BYTE ? LEN : HUNT;
      end
      LEN: if (!empty) begin
        pop = 1'b1;
        err_nxt = head == 8'd0 || head > MAX_L;
        code_nxt = err_nxt ? 2'd1 : err_code;
        state_nxt = err_nxt ? HUNT : PAYLOAD;
      end
      PAYLOAD: if (!empty && out_ready) begin
        pop = 1'b1;
        state_nxt = remaining == 8'd1 ? CSUM : PAYLOAD;
      end
      CSUM: if (!empty) begin
        pop = 1'b1;
        ok_nxt = head == csum;
        err_nxt = head != csum;
        code_nxt = err_nxt ? 2'd2 : err_code;
        state_nxt = HUNT;
      end
    endcase
  end
  always_ff @(posedge ftdi_clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else state <= state_nxt;
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      in_afull <= 1'b0;
      overflow <= 1'b0;
      remaining <= 8'd0;
      csum <= 8'd0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr + AW'(nw);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_nxt;
      in_afull <= CW'(FIFO_DEPTH) - count_nxt < CW'(4);
      overflow <= drop ? 1'b1 : clear_overflow ? 1'b0 : overflow;
      remaining <= state == LEN && pop ? head : state == PAYLOAD && pop ? remaining - 8'd1 : remaining;
      csum <= state == LEN && pop ? head : state == PAYLOAD && pop ? csum + head : csum;
      frame_ok <= ok_nxt;
      frame_err <= err_nxt;
      err_code <= code_nxt;
    end
  end
  assign out_valid = state == PAYLOAD && !empty;
  assign out_data = out_valid ? head : 8'd0;
  assign out_last = out_valid && remaining == 8'd1;
endmodule

// File: tb/tb_ft600_rx_frame_parser.sv
// tb_ft600_rx_frame_parser: scoreboard bench for ft600_rx_frame_parser
module tb_ft600_rx_frame_parser;
  logic ftdi_clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clear_overflow = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0] in_be = '0;
  logic in_afull, out_valid, out_last, frame_ok, frame_err, overflow;
  logic [7:0] out_data;
  logic [1:0] err_code;
  int pass_cnt = 0, total_cnt = 0;
  typedef struct {int kind; logic [8:0] val;} exp_t;
  exp_t q[$];
  ft600_rx_frame_parser dut (
    .ftdi_clk(ftdi_clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_be(in_be),
    .in_afull(in_afull), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );
  always #5 ftdi_clk = ~ftdi_clk;
  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask
  task automatic score(int kind, logic [8:0] val);
    exp_t e;
    total_cnt++;
    if (q.size() == 0) $display("FAIL scoreboard: unexpected kind=%0d val=%0h", kind, val);
    else begin
      e = q.pop_front();
      if (e.kind == kind && e.val === val) pass_cnt++;
      else $display("FAIL scoreboard: got kind=%0d val=%0h required kind=%0d val=%0h", kind, val, e.kind, e.val);
    end
  endtask
  // kind 0: payload byte {last,data}; 1: frame_ok; 2: frame_err with err_code
  always @(negedge ftdi_clk) if (rst_n) begin
    if (out_valid && out_ready) score(0, {out_last, out_data});
    if (frame_ok) score(1, 9'd0);
    if (frame_err) score(2, {7'd0, err_code});
    if (frame_ok && frame_err) begin
      total_cnt++;
      $display("FAIL pulses: got ok=1 err=1 required at most one");
    end
  end
  task automatic exp_byte(logic [7:0] d, logic l);
    q.push_back('{0, {l, d}});
  endtask
  task automatic exp_ok();
    q.push_back('{1, 9'd0});
  endtask
  task automatic exp_err(logic [1:0] c);
    q.push_back('{2, {7'd0, c}});
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge ftdi_clk);
    #1;
  endtask
  task automatic send(logic [15:0] d, logic [1:0] b);
    in_valid = 1'b1;
    in_data = d;
    in_be = b;
    @(posedge ftdi_clk);
    #1;
    in_valid = 1'b0;
    in_be = 2'b00;
  endtask
  task automatic drain();
    int i = 0;
    while (q.size() != 0 && i < 300) begin
      idle(1);
      i++;
    end
    total_cnt++;
    if (q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d outstanding events required 0", q.size());
    idle(5);
  endtask
  task automatic good_frame();
    exp_byte(8'h11, 1'b0);
    exp_byte(8'h22, 1'b0);
    exp_byte(8'h33, 1'b1);
    exp_ok();
    send(16'h03A5, 2'b11);
    send(16'h2211, 2'b11);
    send(16'h6933, 2'b11);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    #12;
    check("rst_in_afull", in_afull, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    good_frame();
    drain();
    exp_byte(8'h11, 1'b0);
    exp_byte(8'h22, 1'b0);
    exp_byte(8'h33, 1'b1);
    exp_err(2'd2);
    send(16'h03A5, 2'b11);
    send(16'h2211, 2'b11);
    send(16'h6A33, 2'b11);
    drain();
    check("csum_err_code", err_code, 2);
    exp_err(2'd1);
    send(16'hFF00, 2'b11);
    send(16'hA55A, 2'b11);
    send(16'h0000, 2'b01);
    good_frame();
    drain();
    check("len_err_code_held", err_code, 1);
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) exp_byte(8'(i), i == 16);
    exp_ok();
    send(16'h10A5, 2'b11);
    for (int i = 0; i < 8; i++) send({8'(2 * i + 2), 8'(2 * i + 1)}, 2'b11);
    check("afull_at_full", in_afull, 1);
    check("no_overflow_yet", overflow, 0);
    send(16'hEEEE, 2'b11);
    check("overflow_set", overflow, 1);
    check("stall_out_valid", out_valid, 1);
    check("stall_out_data", out_data, 8'h01);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    check("overflow_cleared", overflow, 0);
    out_ready = 1'b1;
    idle(3);
    send(16'h0098, 2'b01);
    drain();
    check("afull_released", in_afull, 0);
    check("overflow_stays_clear", overflow, 0);
    exp_byte(8'h7F, 1'b0);
    exp_byte(8'h80, 1'b1);
    exp_ok();
    send(16'h00A5, 2'b01);
    send(16'h0200, 2'b10);
    send(16'h1234, 2'b00);
    send(16'h807F, 2'b11);
    send(16'h0100, 2'b10);
    drain();
    out_ready = 1'b0;
    send(16'h05A5, 2'b11);
    send(16'h0201, 2'b11);
    idle(4);
    check("mid_payload_valid", out_valid, 1);
    check("mid_payload_data", out_data, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_err_code", err_code, 0);
    check("async_rst_in_afull", in_afull, 0);
    @(negedge ftdi_clk);
    rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    idle(2);
    check("post_rst_empty", out_valid, 0);
    good_frame();
    drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
